// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone 16550 UART host: FSM states, UART
// register map, LSR bit positions and the Wishbone request payload.
package wb_uart_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO_W  = 8;

  // 16550 register addresses (DLL/DLM alias RBR_THR/IER while DLAB=1)
  localparam logic [ADDR_W-1:0] ADDR_RBR_THR = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DLL     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DLM     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_FCR     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_LCR     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_LSR     = 3'd5;

  // LSR bit indices
  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_THRE = 5;

  // LCR values: 8N1 with and without the divisor-latch access bit
  localparam logic [DATA_W-1:0] LCR_DLAB_VAL = 8'h83;
  localparam logic [DATA_W-1:0] LCR_8N1_VAL  = 8'h03;

  // Counter value on the last waiting cycle; the 255th unacked cycle abandons
  localparam logic [TMO_W-1:0] TMO_LAST = 8'd254;

  typedef enum logic [3:0] {
    INIT_LCR_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    INIT_FCR,
    IDLE,
    POLL_LSR,
    RD_RBR,
    WR_THR
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_uart_host_skid.sv
// One-entry valid/ready byte buffer.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready_c accept
// side (ready is simply "empty"); out_valid/out_data/out_ready drain side.
// A load and a drain never coincide: loads only happen while empty.
module wb_uart_host_skid
  import wb_uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready_c,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  // Buffer register: fill when empty, empty on drain handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && !full_q) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (out_ready && full_q) begin
      full_q <= 1'b0;
    end
  end

  assign in_ready_c = ~full_q;
  assign out_valid  = full_q;
  assign out_data   = data_q;

endmodule

// File: rtl/wb_uart_host.sv
// Wishbone initiator that programs a 16550 UART and then moves bytes
// between valid/ready streams and the UART by polling LSR.
// Ports: clk, rst (sync, active-high); o_wb_* / i_wb_* classic single-beat
// Wishbone initiator; i_tx_valid/i_tx_data/o_tx_ready transmit stream;
// o_rx_valid/o_rx_data/i_rx_ready receive stream; o_init_done; o_bus_err.
// Build option: WB_UART_HOST_TIMEOUT_EN adds an ack timeout that abandons a
// transaction after 255 unacked cycles and sets the sticky o_bus_err.
module wb_uart_host
  import wb_uart_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd54,
  parameter logic [7:0]  FCR_VAL = 8'h07
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic              o_rx_valid,
  output logic [DATA_W-1:0] o_rx_data,
  input  logic              i_rx_ready,
  output logic              o_init_done,
  output logic              o_bus_err
);

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  wb_req_t           req_q, req_d;
  logic              init_done_q, init_done_d;
  logic              done_c, timeout_c;
  logic [DATA_W-1:0] rdata_c;
  logic              tx_in_ready_c, tx_full, tx_pop_c;
  logic [DATA_W-1:0] tx_byte;
  logic              rx_in_ready_c, rx_full, rx_push_c;

  // Bus request owned by each bus state
  function automatic wb_req_t state_req(input state_t s, input logic [DATA_W-1:0] thr);
    wb_req_t r;
    r = '0;
    case (s)
      INIT_LCR_DLAB: begin r.we = 1'b1; r.addr = ADDR_LCR; r.data = LCR_DLAB_VAL;   end
      INIT_DLL:      begin r.we = 1'b1; r.addr = ADDR_DLL; r.data = DIVISOR[7:0];   end
      INIT_DLM:      begin r.we = 1'b1; r.addr = ADDR_DLM; r.data = DIVISOR[15:8];  end
      INIT_LCR:      begin r.we = 1'b1; r.addr = ADDR_LCR; r.data = LCR_8N1_VAL;    end
      INIT_FCR:      begin r.we = 1'b1; r.addr = ADDR_FCR; r.data = FCR_VAL;        end
      RD_RBR:        r.addr = ADDR_RBR_THR;
      WR_THR:        begin r.we = 1'b1; r.addr = ADDR_RBR_THR; r.data = thr;        end
      default:       r.addr = ADDR_LSR;
    endcase
    return r;
  endfunction

`ifdef WB_UART_HOST_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             bus_err_q;

  assign timeout_c = cyc_q & ~i_wb_ack & (tmo_cnt_q == TMO_LAST);

  // Unacked-cycle counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (!cyc_q || i_wb_ack) tmo_cnt_q <= '0;
      else                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      if (timeout_c)          bus_err_q <= 1'b1;
    end
  end

  assign o_bus_err = bus_err_q;
`else
  assign timeout_c = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  // An abandoned transaction completes as if acked with zero read data
  assign done_c  = cyc_q & (i_wb_ack | timeout_c);
  assign rdata_c = i_wb_ack ? i_wb_data : '0;

  // State and bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_LCR_DLAB;
      cyc_q       <= 1'b0;
      req_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      req_q       <= req_d;
      init_done_q <= init_done_d;
    end
  end

  // Next state and bus request. A bus state entered with cyc low issues its
  // request, which guarantees one idle bus cycle between transactions.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    req_d       = req_q;
    init_done_d = init_done_q;
    tx_pop_c    = 1'b0;
    rx_push_c   = 1'b0;
    if (state_q == IDLE) begin
      if (init_done_q && (!rx_full || tx_full)) begin
        state_d = POLL_LSR;
        cyc_d   = 1'b1;
        req_d   = state_req(POLL_LSR, tx_byte);
      end
    end else if (!cyc_q) begin
      cyc_d = 1'b1;
      req_d = state_req(state_q, tx_byte);
    end else if (done_c) begin
      cyc_d = 1'b0;
      case (state_q)
        INIT_LCR_DLAB: state_d = INIT_DLL;
        INIT_DLL:      state_d = INIT_DLM;
        INIT_DLM:      state_d = INIT_LCR;
        INIT_LCR:      state_d = INIT_FCR;
        INIT_FCR: begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
        POLL_LSR: begin
          if (rdata_c[LSR_DR] && !rx_full)      state_d = RD_RBR;
          else if (rdata_c[LSR_THRE] && tx_full) state_d = WR_THR;
          else                                   state_d = IDLE;
        end
        RD_RBR: begin
          rx_push_c = 1'b1;
          state_d   = IDLE;
        end
        WR_THR: begin
          tx_pop_c = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  wb_uart_host_skid u_tx_buf (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (i_tx_valid & init_done_q),
    .in_data    (i_tx_data),
    .in_ready_c (tx_in_ready_c),
    .out_valid  (tx_full),
    .out_data   (tx_byte),
    .out_ready  (tx_pop_c)
  );

  wb_uart_host_skid u_rx_buf (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (rx_push_c),
    .in_data    (rdata_c),
    .in_ready_c (rx_in_ready_c),
    .out_valid  (o_rx_valid),
    .out_data   (o_rx_data),
    .out_ready  (i_rx_ready)
  );

  assign rx_full     = ~rx_in_ready_c;
  assign o_tx_ready  = init_done_q & tx_in_ready_c;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_wb_we     = req_q.we;
  assign o_wb_addr   = req_q.addr;
  assign o_wb_data   = req_q.data;
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_wb_uart_host.sv
// Directed self-checking bench for wb_uart_host with a Wishbone responder
// model that logs every acked request as {we, addr, data}.
module tb_wb_uart_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0] o_wb_addr;
  logic [7:0] o_wb_data;
  logic       i_wb_ack;
  logic [7:0] i_wb_data;
  logic       i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready;
  logic       o_rx_valid;
  logic [7:0] o_rx_data;
  logic       i_rx_ready;
  logic       o_init_done;
  logic       o_bus_err;

  int errors = 0;
  int checks = 0;

  logic        resp_en;
  logic [7:0]  lsr_val, rbr_val;
  logic [11:0] log_q[$];
  logic [11:0] exp_init[5];

  always #5 clk = ~clk;

  wb_uart_host dut (
    .clk         (clk),
    .rst         (rst),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_addr   (o_wb_addr),
    .o_wb_data   (o_wb_data),
    .i_wb_ack    (i_wb_ack),
    .i_wb_data   (i_wb_data),
    .i_tx_valid  (i_tx_valid),
    .i_tx_data   (i_tx_data),
    .o_tx_ready  (o_tx_ready),
    .o_rx_valid  (o_rx_valid),
    .o_rx_data   (o_rx_data),
    .i_rx_ready  (i_rx_ready),
    .o_init_done (o_init_done),
    .o_bus_err   (o_bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Log entries: upper nibble {we, addr} identifies the access kind
  function automatic int count_kind(input logic [3:0] kind);
    int c = 0;
    foreach (log_q[i]) if (log_q[i][11:8] == kind) c++;
    return c;
  endfunction

  function automatic int first_kind(input logic [3:0] kind);
    foreach (log_q[i]) if (log_q[i][11:8] == kind) return i;
    return -1;
  endfunction

  // Responder: acks on the second negedge of a request, checks stability
  initial begin
    int          cnt;
    logic [11:0] lat;
    cnt = 0;
    lat = '0;
    i_wb_ack  = 1'b0;
    i_wb_data = 8'h00;
    forever begin
      @(negedge clk);
      if (o_wb_cyc && o_wb_stb) begin
        if (cnt == 0) lat = {o_wb_we, o_wb_addr, o_wb_data};
        else          chk("wb_req_stable", {o_wb_we, o_wb_addr, o_wb_data}, lat);
        i_wb_ack = resp_en && (cnt == 1);
        if (i_wb_ack) begin
          i_wb_data = (o_wb_addr == 3'd5) ? lsr_val : (o_wb_addr == 3'd0) ? rbr_val : 8'h00;
          log_q.push_back(lat);
        end
        cnt++;
      end else begin
        cnt       = 0;
        i_wb_ack  = 1'b0;
        i_wb_data = 8'h00;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, rd_i, wr_i;
    logic prev;
    exp_init[0] = 12'hB83;
    exp_init[1] = 12'h836;
    exp_init[2] = 12'h900;
    exp_init[3] = 12'hB03;
    exp_init[4] = 12'hA07;
    rst = 1'b1; resp_en = 1'b1; lsr_val = 8'h00; rbr_val = 8'h00;
    i_tx_valid = 1'b0; i_tx_data = 8'h00; i_rx_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_bus", {o_wb_we, o_wb_addr, o_wb_data}, 0);
    chk("rst_streams", {o_tx_ready, o_rx_valid, o_rx_data}, 0);
    chk("rst_flags", {o_init_done, o_bus_err}, 0);

    // Init sequence
    log_q.delete();
    rst = 1'b0;
    n = 0; prev = 1'b0;
    while (log_q.size() < 5 && n < 100) begin prev = o_init_done; tick(); n++; end
    chk("init_bound", n < 100, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("init_wr%0d", i), (log_q.size() > i) ? log_q[i] : 12'hFFF, exp_init[i]);
    chk("init_done_before", prev, 0);
    chk("init_done_after", o_init_done, 1);

    // TX path: LSR=60 gives one THR write
    lsr_val = 8'h60;
    tick();
    log_q.delete();
    chk("tx_ready_idle", o_tx_ready, 1);
    i_tx_valid = 1'b1; i_tx_data = 8'hA5;
    tick();
    i_tx_valid = 1'b0;
    chk("tx_ready_full", o_tx_ready, 0);
    n = 0; prev = 1'b0;
    while (count_kind(4'h8) < 1 && n < 60) begin prev = o_tx_ready; tick(); n++; end
    chk("tx_bound", n < 60, 1);
    chk("tx_ready_before_ack", prev, 0);
    chk("tx_ready_after_ack", o_tx_ready, 1);
    wr_i = first_kind(4'h8);
    chk("tx_thr_write", (wr_i >= 0) ? log_q[wr_i] : 12'hFFF, 12'h8A5);
    repeat (20) tick();
    chk("tx_single_write", count_kind(4'h8), 1);

    // RX path: LSR=61, RBR=3C, held until accepted
    lsr_val = 8'h61; rbr_val = 8'h3C;
    log_q.delete();
    n = 0;
    while (!o_rx_valid && n < 60) begin tick(); n++; end
    chk("rx_valid", o_rx_valid, 1);
    chk("rx_data", o_rx_data, 8'h3C);
    repeat (30) tick();
    chk("rx_held_valid", o_rx_valid, 1);
    chk("rx_held_data", o_rx_data, 8'h3C);
    chk("rx_single_read", count_kind(4'h0), 1);
    lsr_val = 8'h00;
    i_rx_ready = 1'b1;
    tick();
    i_rx_ready = 1'b0;
    chk("rx_accepted", o_rx_valid, 0);
    repeat (10) tick();
    chk("rx_no_new", o_rx_valid, 0);

    // RX has priority over a pending TX byte
    i_tx_valid = 1'b1; i_tx_data = 8'h5A;
    tick();
    i_tx_valid = 1'b0;
    repeat (5) tick();
    log_q.delete();
    lsr_val = 8'h61; rbr_val = 8'hC3;
    n = 0;
    while (count_kind(4'h8) < 1 && n < 80) begin tick(); n++; end
    rd_i = first_kind(4'h0);
    wr_i = first_kind(4'h8);
    chk("prio_rd_before_wr", (rd_i >= 0) && (wr_i > rd_i), 1);
    chk("prio_thr_write", (wr_i >= 0) ? log_q[wr_i] : 12'hFFF, 12'h85A);
    chk("prio_rx_data", o_rx_data, 8'hC3);
    lsr_val = 8'h00;
    i_rx_ready = 1'b1;
    tick();
    i_rx_ready = 1'b0;

    // Responder stops acking
    n = 0;
    while (o_wb_cyc && n < 10) begin tick(); n++; end
    resp_en = 1'b0;
    n = 0;
    while (!o_wb_cyc && n < 10) begin tick(); n++; end
    chk("noack_issue", o_wb_cyc, 1);
    hi = 0;
    while (o_wb_cyc && hi < 400) begin hi++; tick(); end
`ifdef WB_UART_HOST_TIMEOUT_EN
    chk("tmo_cycles", hi, 255);
    chk("tmo_stb_low", o_wb_stb, 0);
    chk("tmo_bus_err", o_bus_err, 1);
`else
    chk("noack_cycles", hi, 400);
    chk("noack_stb_held", o_wb_stb, 1);
    chk("noack_bus_err", o_bus_err, 0);
`endif

    // Reset mid-transaction, then reset during INIT_DLM
    rst = 1'b1;
    tick();
    chk("rst2_cyc", o_wb_cyc, 0);
    chk("rst2_flags", {o_init_done, o_bus_err, o_tx_ready, o_rx_valid}, 0);
    resp_en = 1'b1;
    log_q.delete();
    rst = 1'b0;
    n = 0;
    while (!(o_wb_cyc && o_wb_addr == 3'd1) && n < 50) begin tick(); n++; end
    chk("dlm_reached", {o_wb_cyc, o_wb_we, o_wb_addr}, 5'b11001);
    chk("dlm_prior_acks", log_q.size(), 2);
    rst = 1'b1;
    tick();
    chk("dlm_rst_cyc", o_wb_cyc, 0);
    chk("dlm_rst_stb", o_wb_stb, 0);
    log_q.delete();
    rst = 1'b0;
    n = 0;
    while (log_q.size() < 5 && n < 100) begin tick(); n++; end
    for (int i = 0; i < 5; i++) chk($sformatf("reinit_wr%0d", i), (log_q.size() > i) ? log_q[i] : 12'hFFF, exp_init[i]);
    chk("reinit_done", o_init_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_uart_host.md
WB_UART_HOST -- requirements
Module: wb_uart_host

Interface
REQ-001 Parameter DIVISOR, default 16'd54, 16550 divisor latch value programmed at init.
REQ-002 Parameter FCR_VAL, default 8'h07, FIFO control value programmed at init.
REQ-003 clk  input  1  the single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone initiator cycle, strobe and write-enable.
REQ-006 o_wb_addr  output  3  UART register address; o_wb_data  output  8  write data.
REQ-007 i_wb_ack  input  1  responder ack; i_wb_data  input  8  read data, valid with ack.
REQ-008 i_tx_valid  input  1, i_tx_data  input  8, o_tx_ready  output  1  byte stream to transmit.
REQ-009 o_rx_valid  output  1, o_rx_data  output  8, i_rx_ready  input  1  received byte stream.
REQ-010 o_init_done  output  1  UART programmed; o_bus_err  output  1  sticky ack-timeout flag.

Function
REQ-011 Bus SHALL be single-beat classic Wishbone: cyc=stb=1 with addr/we/data stable from issue until the cycle i_wb_ack=1, both dropped the cycle after ack; cyc/stb SHALL stay low at least one cycle between transactions.
REQ-012 Init sequence SHALL be five writes in order: addr3=8'h83, addr0=DIVISOR[7:0], addr1=DIVISOR[15:8], addr3=8'h03, addr2=FCR_VAL; o_init_done SHALL rise the cycle after the fifth ack and stay high until reset.
REQ-013 FSM states: INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, IDLE, POLL_LSR, RD_RBR, WR_THR; each bus state advances only on ack.
REQ-014 IDLE SHALL issue a read of addr5 (LSR) next cycle whenever rx buffer is empty or tx buffer is full; otherwise stay IDLE with bus idle.
REQ-015 After LSR ack: if LSR[0]=1 and rx buffer empty -> RD_RBR (read addr0); else if LSR[5]=1 and tx buffer full -> WR_THR (write addr0 = tx buffer); else -> IDLE. RX takes priority.
REQ-016 TX buffer: one byte; o_tx_ready = init_done & ~tx_full; handshake loads buffer; WR_THR ack empties it; o_tx_ready SHALL be combinationally independent of i_tx_valid.
REQ-017 RX buffer: one byte; RD_RBR ack loads i_wb_data and sets o_rx_valid next cycle; o_rx_valid&i_rx_ready clears it; o_rx_data stable while o_rx_valid=1 and not accepted.
REQ-018 Simultaneous tx handshake and THR ack cannot occur (ready low while full); simultaneous rx accept and RBR ack cannot occur (RBR read only when empty).
REQ-019 Streams SHALL be ignored (o_tx_ready=0, no LSR polling) before o_init_done.

Reset
REQ-020 On rst: o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_addr=0, o_wb_data=0, o_tx_ready=0, o_rx_valid=0, o_rx_data=0, o_init_done=0, o_bus_err=0, both buffers empty, FSM=INIT_LCR_DLAB.
REQ-021 Reset asserted mid-transaction SHALL drop cyc/stb the next cycle, discard buffered bytes, and restart the full init sequence after release.

Configuration
REQ-022 With WB_UART_HOST_TIMEOUT_EN defined: an 8-bit counter counts cycles with stb=1 and no ack; at 255 the transaction is abandoned (cyc/stb low next cycle), o_bus_err set sticky until reset, FSM returns to the state's successor as if acked with read data 8'h00.
REQ-023 Without WB_UART_HOST_TIMEOUT_EN: no counter, o_bus_err tied 0, FSM waits for ack indefinitely.

Structure
REQ-024 Shared package wb_uart_pkg SHALL hold the FSM state enum, register address constants (RBR_THR=0, DLM=1, FCR=2, LCR=3, LSR=5) and LSR bit indices (DR=0, THRE=5).
REQ-025 One sub-module wb_uart_host_skid (one-entry valid/ready byte buffer) SHALL be instantiated twice for TX and RX buffers.

Verification
REQ-026 Reset release, responder acks every request after 1 cycle -> writes 83,36,00,03,07 to addrs 3,0,1,3,2 in order; o_init_done=1 after fifth ack.
REQ-027 After init, push 8'hA5 on tx, LSR returns 8'h60 -> one write addr0 data A5; o_tx_ready high again the cycle after that ack.
REQ-028 LSR returns 8'h61, RBR returns 8'h3C, i_rx_ready=0 -> o_rx_valid=1, o_rx_data=3C held; no further RBR read until i_rx_ready pulses.
REQ-029 TX byte pending and LSR=8'h61 -> RBR read occurs before THR write.
REQ-030 Responder never acks, macro defined -> cyc/stb drop after 255 cycles, o_bus_err=1; macro undefined -> stb held indefinitely, o_bus_err=0.
REQ-031 rst pulsed during INIT_DLM stb -> cyc/stb low next cycle; init sequence restarts from addr3=83.
